// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment capture path.
// Optional hex decode is enabled by defining SEG_CAPTURE_HEX_EN.
package seg_pkg;

  // Bit positions on the active-low segment bus.
  localparam int SEG_W     = 7;
  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} seg_state_t;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] value;
  } seg_dec_t;

endpackage

// File: rtl/seg_capture_if.sv
// Display-bus bundle between the scanner side and the seg_capture reader.
interface seg_capture_if #(
  parameter int NUM_DIGITS = 4
);
  import seg_pkg::*;

  // No valid/ready handshake: inputs are sampled every cycle with no
  // backpressure, and update/err are single-cycle pulses the consumer must
  // observe in the cycle they are high.
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    update;
  logic                    err;
  seg_state_t              state;

  modport master (
    output seg_in, an_in, clear,
    input  bcd_out, digit_valid, update, err, state
  );

  modport slave (
    input  seg_in, an_in, clear,
    output bcd_out, digit_valid, update, err, state
  );

endinterface

// File: rtl/seg2bcd.sv
// Combinational active-low segment pattern decoder.
// Hex digits A-F decode only when SEG_CAPTURE_HEX_EN is defined.
module seg2bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output seg_dec_t   dec
);

  always_comb begin
    dec = '0;
    case (seg)
      SEG_0: begin dec.valid = 1'b1; dec.value = 4'd0; end
      SEG_1: begin dec.valid = 1'b1; dec.value = 4'd1; end
      SEG_2: begin dec.valid = 1'b1; dec.value = 4'd2; end
      SEG_3: begin dec.valid = 1'b1; dec.value = 4'd3; end
      SEG_4: begin dec.valid = 1'b1; dec.value = 4'd4; end
      SEG_5: begin dec.valid = 1'b1; dec.value = 4'd5; end
      SEG_6: begin dec.valid = 1'b1; dec.value = 4'd6; end
      SEG_7: begin dec.valid = 1'b1; dec.value = 4'd7; end
      SEG_8: begin dec.valid = 1'b1; dec.value = 4'd8; end
      SEG_9: begin dec.valid = 1'b1; dec.value = 4'd9; end
`ifdef SEG_CAPTURE_HEX_EN
      SEG_A: begin dec.valid = 1'b1; dec.value = 4'hA; end
      SEG_B: begin dec.valid = 1'b1; dec.value = 4'hB; end
      SEG_C: begin dec.valid = 1'b1; dec.value = 4'hC; end
      SEG_D: begin dec.valid = 1'b1; dec.value = 4'hD; end
      SEG_E: begin dec.valid = 1'b1; dec.value = 4'hE; end
      SEG_F: begin dec.valid = 1'b1; dec.value = 4'hF; end
`else
`endif
      SEG_BLANK: dec.blank = 1'b1;
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Debounces the multiplexed seven-segment bus and stores one decoded digit
// per anode. Hex decode is enabled by defining SEG_CAPTURE_HEX_EN.
module seg_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_capture_if.slave  bus
);

  localparam int SW = 7 + NUM_DIGITS;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]           sample, s_reg;
  logic [CW-1:0]           cnt, cnt_next;
  seg_state_t              state, state_next;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    update_q, err_q, err_d;
  logic [NUM_DIGITS-1:0]   an_act;
  logic                    changed, any_low, one_low, capture;
  seg_dec_t                dec;

  assign sample  = {bus.seg_in, bus.an_in};
  assign changed = (sample != s_reg);
  assign an_act  = ~s_reg[NUM_DIGITS-1:0];
  assign any_low = |an_act;
  assign one_low = any_low && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);

  seg2bcd u_dec (
    .seg (s_reg[SW-1:NUM_DIGITS]),
    .dec (dec)
  );

  // Capture fires on the edge the counter would reach STABLE_CYCLES, so the
  // decoded s_reg equals the incoming sample on that edge.
  assign capture = (state == SETTLE) && !changed && (cnt == CNT_LAST) && any_low;

  always_comb begin
    cnt_next = cnt;
    if (changed)             cnt_next = '0;
    else if (cnt != CNT_MAX) cnt_next = cnt + CW'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_low) state_next = SETTLE;
      SETTLE: begin
        if (!any_low)    state_next = IDLE;
        else if (capture) state_next = HELD;
      end
      HELD:    if (changed) state_next = (&bus.an_in) ? IDLE : SETTLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bcd_d   = bcd_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    if (bus.clear) begin
      bcd_d   = '0;
      valid_d = '0;
    end else if (capture) begin
      if (!one_low) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (an_act[i]) begin
            if (dec.valid) begin
              bcd_d[4*i +: 4] = dec.value;
              valid_d[i]      = 1'b1;
            end else begin
              valid_d[i] = 1'b0;
              if (!dec.blank) err_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_reg    <= '1;
      cnt      <= '0;
      state    <= IDLE;
      bcd_q    <= '0;
      valid_q  <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s_reg    <= sample;
      cnt      <= cnt_next;
      state    <= state_next;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      update_q <= (bcd_d != bcd_q) || (valid_d != valid_q);
      err_q    <= err_d;
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.digit_valid = valid_q;
  assign bus.update      = update_q;
  assign bus.err         = err_q;
  assign bus.state       = state;

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: directed scenarios plus randomized
// traffic against a run-length based behavioural model.
module tb_seg_capture;
  import seg_pkg::*;

  localparam int N = 4;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg_capture_if #(.NUM_DIGITS(N)) bus();

  seg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: length of the current run of identical inputs.
  logic [6:0]   pat_tab [16];
  logic [6:0]   last_seg;
  logic [N-1:0] last_an;
  int           run;
  logic [4*N-1:0] m_bcd;
  logic [N-1:0]   m_valid;
  logic           m_update, m_err;

  function automatic int decode(input logic [6:0] p);
    for (int v = 0; v < 10; v++) if (p == pat_tab[v]) return v;
`ifdef SEG_CAPTURE_HEX_EN
    for (int v = 10; v < 16; v++) if (p == pat_tab[v]) return v;
`endif
    if (p == 7'h7F) return -1;
    return -2;
  endfunction

  task automatic model_edge();
    int nlow, idx, v;
    logic [4*N-1:0] nb;
    logic [N-1:0]   nv;
    logic           e;
    if (!rst_n) begin
      run = 0; m_bcd = '0; m_valid = '0; m_update = 1'b0; m_err = 1'b0;
      return;
    end
    if (run > 0 && bus.seg_in == last_seg && bus.an_in == last_an) run++;
    else run = 1;
    last_seg = bus.seg_in;
    last_an  = bus.an_in;
    nb = m_bcd; nv = m_valid; e = 1'b0;
    nlow = 0; idx = 0;
    for (int i = 0; i < N; i++) if (!bus.an_in[i]) begin nlow++; idx = i; end
    if (bus.clear) begin
      nb = '0; nv = '0;
    end else if (run == S + 1 && nlow > 0) begin
      if (nlow > 1) e = 1'b1;
      else begin
        v = decode(bus.seg_in);
        if (v >= 0) begin nb[4*idx +: 4] = v[3:0]; nv[idx] = 1'b1; end
        else begin nv[idx] = 1'b0; if (v == -2) e = 1'b1; end
      end
    end
    m_update = (nb != m_bcd) || (nv != m_valid);
    m_bcd = nb; m_valid = nv; m_err = e;
  endtask

  task automatic cycle(input logic [6:0] seg, input logic [N-1:0] an, input logic clr);
    bus.seg_in = seg; bus.an_in = an; bus.clear = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) cycle(7'h7F, '1, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_checks++; if (bus.bcd_out !== '0) begin n_fail++; $display("FAIL reset_bcd got %h expected 0", bus.bcd_out); end
    n_checks++; if (bus.digit_valid !== '0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", bus.digit_valid); end
    n_checks++; if (bus.update !== 1'b0) begin n_fail++; $display("FAIL reset_update got %b expected 0", bus.update); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", bus.err); end
  endtask

  task automatic test_single_capture();
    int early = 0;
    for (int i = 0; i < S; i++) begin
      cycle(7'b1111001, 4'b1110, 1'b0);
      if (bus.digit_valid !== '0 || bus.update !== 1'b0) early++;
    end
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL single_early got %0d early events expected 0", early); end
    cycle(7'b1111001, 4'b1110, 1'b0);
    n_checks++; if (bus.bcd_out[3:0] !== 4'd1) begin n_fail++; $display("FAIL single_bcd got %h expected 1", bus.bcd_out[3:0]); end
    n_checks++; if (bus.digit_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid got %b expected 0001", bus.digit_valid); end
    n_checks++; if (bus.update !== 1'b1) begin n_fail++; $display("FAIL single_update got %b expected 1", bus.update); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL single_err got %b expected 0", bus.err); end
    cycle(7'b1111001, 4'b1110, 1'b0);
    n_checks++; if (bus.update !== 1'b0) begin n_fail++; $display("FAIL single_pulse_len got %b expected 0", bus.update); end
  endtask

  task automatic test_short_hold();
    int ups = 0;
    do_reset(1);
    for (int i = 0; i < S; i++) begin cycle(7'b1111001, 4'b1110, 1'b0); if (bus.update) ups++; end
    for (int i = 0; i < 4; i++) begin cycle(7'h7F, 4'b1111, 1'b0); if (bus.update) ups++; end
    n_checks++; if (bus.digit_valid !== '0 || bus.bcd_out !== '0) begin n_fail++; $display("FAIL short_outputs got %b/%h expected 0/0", bus.digit_valid, bus.bcd_out); end
    n_checks++; if (ups !== 0) begin n_fail++; $display("FAIL short_update got %0d pulses expected 0", ups); end
  endtask

  task automatic scan(output int ups, output int errs);
    logic [6:0]   pats [4];
    logic [N-1:0] ans  [4];
    pats[0] = 7'b0010010; pats[1] = 7'b0010000; pats[2] = 7'b1000000; pats[3] = 7'b0110000;
    ans[0] = 4'b1110; ans[1] = 4'b1101; ans[2] = 4'b1011; ans[3] = 4'b0111;
    ups = 0; errs = 0;
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 10; i++) begin
        cycle(pats[d], ans[d], 1'b0);
        if (bus.update) ups++;
        if (bus.err) errs++;
      end
  endtask

  task automatic test_scan();
    int ups, errs;
    scan(ups, errs);
    n_checks++; if (bus.bcd_out !== 16'h3095) begin n_fail++; $display("FAIL scan_bcd got %h expected 3095", bus.bcd_out); end
    n_checks++; if (bus.digit_valid !== 4'b1111) begin n_fail++; $display("FAIL scan_valid got %b expected 1111", bus.digit_valid); end
    n_checks++; if (ups !== 4) begin n_fail++; $display("FAIL scan_updates got %0d expected 4", ups); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL scan_err got %0d expected 0", errs); end
    scan(ups, errs);
    n_checks++; if (ups !== 0) begin n_fail++; $display("FAIL rescan_updates got %0d expected 0", ups); end
    n_checks++; if (bus.bcd_out !== 16'h3095) begin n_fail++; $display("FAIL rescan_bcd got %h expected 3095", bus.bcd_out); end
  endtask

  task automatic test_invalid();
    int errs = 0;
    for (int i = 0; i < 10; i++) begin cycle(7'b0111111, 4'b1101, 1'b0); if (bus.err) errs++; end
    n_checks++; if (errs !== 1) begin n_fail++; $display("FAIL invalid_err got %0d pulses expected 1", errs); end
    n_checks++; if (bus.digit_valid !== 4'b1101) begin n_fail++; $display("FAIL invalid_valid got %b expected 1101", bus.digit_valid); end
    n_checks++; if (bus.bcd_out[7:4] !== 4'd9) begin n_fail++; $display("FAIL invalid_bcd got %h expected 9", bus.bcd_out[7:4]); end
  endtask

  task automatic test_multi_anode();
    int errs = 0, ups = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(7'b1111001, 4'b1100, 1'b0);
      if (bus.err) errs++;
      if (bus.update) ups++;
    end
    n_checks++; if (errs !== 1) begin n_fail++; $display("FAIL multi_err got %0d pulses expected 1", errs); end
    n_checks++; if (ups !== 0) begin n_fail++; $display("FAIL multi_update got %0d pulses expected 0", ups); end
    n_checks++; if (bus.bcd_out !== 16'h3095 || bus.digit_valid !== 4'b1101) begin n_fail++; $display("FAIL multi_hold got %h/%b expected 3095/1101", bus.bcd_out, bus.digit_valid); end
  endtask

  task automatic test_clear_vs_capture();
    for (int i = 0; i < S; i++) cycle(7'b1111000, 4'b1110, 1'b0);
    cycle(7'b1111000, 4'b1110, 1'b1);
    n_checks++; if (bus.digit_valid !== '0 || bus.bcd_out !== '0) begin n_fail++; $display("FAIL clear_outputs got %b/%h expected 0/0", bus.digit_valid, bus.bcd_out); end
    n_checks++; if (bus.update !== 1'b1) begin n_fail++; $display("FAIL clear_update got %b expected 1", bus.update); end
    for (int i = 0; i < 5; i++) cycle(7'b1111000, 4'b1110, 1'b0);
    n_checks++; if (bus.digit_valid !== '0) begin n_fail++; $display("FAIL clear_discard got %b expected 0000", bus.digit_valid); end
    for (int i = 0; i < 3; i++) cycle(7'h7F, 4'b1111, 1'b0);
  endtask

  task automatic test_hex();
    int errs = 0;
    for (int i = 0; i < 10; i++) begin cycle(7'b0001000, 4'b1110, 1'b0); if (bus.err) errs++; end
`ifdef SEG_CAPTURE_HEX_EN
    n_checks++; if (bus.bcd_out[3:0] !== 4'hA || bus.digit_valid[0] !== 1'b1) begin n_fail++; $display("FAIL hex_decode got %h/%b expected a/1", bus.bcd_out[3:0], bus.digit_valid[0]); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL hex_err got %0d expected 0", errs); end
`else
    n_checks++; if (bus.digit_valid[0] !== 1'b0 || bus.bcd_out[3:0] !== 4'h0) begin n_fail++; $display("FAIL hex_invalid got %h/%b expected 0/0", bus.bcd_out[3:0], bus.digit_valid[0]); end
    n_checks++; if (errs !== 1) begin n_fail++; $display("FAIL hex_err got %0d expected 1", errs); end
`endif
  endtask

  task automatic test_reset_mid_settle();
    int ups = 0;
    do_reset(1);
    for (int i = 0; i < 5; i++) cycle(7'b0100100, 4'b1011, 1'b0);
    rst_n = 1'b0;
    cycle(7'b0100100, 4'b1011, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < S; i++) begin cycle(7'b0100100, 4'b1011, 1'b0); if (bus.update) ups++; end
    for (int i = 0; i < 3; i++) begin cycle(7'h7F, 4'b1111, 1'b0); if (bus.update) ups++; end
    n_checks++; if (bus.digit_valid !== '0) begin n_fail++; $display("FAIL midreset_valid got %b expected 0000", bus.digit_valid); end
    n_checks++; if (ups !== 0) begin n_fail++; $display("FAIL midreset_update got %0d expected 0", ups); end
  endtask

  task automatic test_random();
    logic [6:0]   seg;
    logic [N-1:0] an;
    int           hold, r;
    int           cyc = 0;
    do_reset(1);
    while (cyc < 1500) begin
      r = $urandom_range(0, 9);
      if (r <= 5 || r == 9) seg = pat_tab[$urandom_range(0, 9)];
      else if (r == 6) seg = 7'h7F;
      else if (r == 7) seg = pat_tab[$urandom_range(10, 15)];
      else seg = 7'($urandom_range(0, 127));
      r = $urandom_range(0, 9);
      if (r == 7) an = '1;
      else if (r == 8) an = N'($urandom_range(0, (1 << N) - 1));
      else begin an = '1; an[$urandom_range(0, N - 1)] = 1'b0; end
      hold = $urandom_range(1, 13);
      for (int h = 0; h < hold; h++) begin
        cycle(seg, an, ($urandom_range(0, 39) == 0));
        cyc++;
        n_checks++; if (bus.bcd_out !== m_bcd) begin n_fail++; $display("FAIL rand_bcd cycle %0d got %h expected %h", cyc, bus.bcd_out, m_bcd); end
        n_checks++; if (bus.digit_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid cycle %0d got %b expected %b", cyc, bus.digit_valid, m_valid); end
        n_checks++; if (bus.update !== m_update) begin n_fail++; $display("FAIL rand_update cycle %0d got %b expected %b", cyc, bus.update, m_update); end
        n_checks++; if (bus.err !== m_err) begin n_fail++; $display("FAIL rand_err cycle %0d got %b expected %b", cyc, bus.err, m_err); end
      end
    end
  endtask

  initial begin
    pat_tab[0]  = 7'b1000000; pat_tab[1]  = 7'b1111001; pat_tab[2]  = 7'b0100100;
    pat_tab[3]  = 7'b0110000; pat_tab[4]  = 7'b0011001; pat_tab[5]  = 7'b0010010;
    pat_tab[6]  = 7'b0000010; pat_tab[7]  = 7'b1111000; pat_tab[8]  = 7'b0000000;
    pat_tab[9]  = 7'b0010000; pat_tab[10] = 7'b0001000; pat_tab[11] = 7'b0000011;
    pat_tab[12] = 7'b1000110; pat_tab[13] = 7'b0100001; pat_tab[14] = 7'b0000110;
    pat_tab[15] = 7'b0001110;
    last_seg = 7'h7F; last_an = '1; run = 0;
    m_bcd = '0; m_valid = '0; m_update = 1'b0; m_err = 1'b0;
    bus.seg_in = 7'h7F; bus.an_in = '1; bus.clear = 1'b0;

    test_reset();
    test_single_capture();
    test_short_hold();
    test_scan();
    test_invalid();
    test_multi_anode();
    test_clear_vs_capture();
    test_hex();
    test_reset_mid_settle();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
